// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] NOP_WORD_DEF   = 32'h0000_0000;
    localparam logic [PC_W-1:0] PROG_BYTES_DEF = 32'd48;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    // Redirect targets are byte addresses; fetch is always word aligned.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus and IF/ID register outputs of the fetch stage.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [PC_W-1:0] imem_addr;
    logic [PC_W-1:0] imem_instr;
    logic [PC_W-1:0] ifid_instr;
    logic [PC_W-1:0] ifid_pc4;
    logic            ifid_valid;

    modport master (
        output imem_addr,
        input  imem_instr,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid
    );

endinterface

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register: bubble beats load; neither asserted means hold.
module ifid_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            bubble,
    input  logic [PC_W-1:0] d_instr,
    input  logic [PC_W-1:0] d_pc4,
    output logic [PC_W-1:0] q_instr,
    output logic [PC_W-1:0] q_pc4,
    output logic            q_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_instr <= NOP_WORD;
            q_pc4   <= '0;
            q_valid <= 1'b0;
        end else if (bubble) begin
            q_instr <= NOP_WORD;
            q_pc4   <= '0;
            q_valid <= 1'b0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc4   <= d_pc4;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, next-PC selection and program start/done sequencing.
//   state   | meaning
//   IDLE    | waiting for start, pc at reset value, IF/ID bubbled
//   RUN     | fetching; redirects, stalls and end-of-image handled
//   DONE    | image exhausted, done=1, only start is honoured
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET   = 32'h0000_0000,
    parameter logic [PC_W-1:0] PROG_BYTES = PROG_BYTES_DEF,
    parameter logic [PC_W-1:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic            done,
    fetch_unit_if.master    bus
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc4;
    logic            pc_end;
    logic            ifid_load;
    logic            ifid_bubble;
    logic [PC_W-1:0] q_instr;
    logic [PC_W-1:0] q_pc4;
    logic            q_valid;

    assign pc4           = pc + 32'd4;
    assign pc_end        = (pc >= PROG_BYTES);
    assign bus.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= PC_RESET;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc    <= PC_RESET;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (jump) begin
                        pc <= word_align(jump_target);
                    end else if (branch_taken) begin
                        pc <= word_align(branch_target);
                    end else if (stall) begin
                        pc <= pc;
                    end else if (pc_end) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        pc <= pc4;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        pc    <= PC_RESET;
                        done  <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    pc    <= PC_RESET;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID only loads or holds while running; every other case is a bubble.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b1;
        if (state == ST_RUN && !jump && !branch_taken) begin
            if (stall) begin
                ifid_bubble = 1'b0;
            end else if (!pc_end) begin
                ifid_load   = 1'b1;
                ifid_bubble = 1'b0;
            end
        end
    end

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ifid_load),
        .bubble  (ifid_bubble),
        .d_instr (bus.imem_instr),
        .d_pc4   (pc4),
        .q_instr (q_instr),
        .q_pc4   (q_pc4),
        .q_valid (q_valid)
    );

    assign bus.ifid_instr = q_instr;
    assign bus.ifid_pc4   = q_pc4;
    assign bus.ifid_valid = q_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 12-word instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        done;

    int n_checks;
    int n_fail;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .done          (done),
        .bus           (bus.master)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a < 32'd48) return 32'h2400_0000 | a;
        return 32'hFFFF_FFFF;
    endfunction

    assign bus.imem_instr = word_at(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc4, input logic [31:0] instr,
                              input logic valid);
        check({tag, " pc4"}, bus.ifid_pc4, pc4);
        check({tag, " instr"}, bus.ifid_instr, instr);
        check({tag, " valid"}, {31'd0, bus.ifid_valid}, {31'd0, valid});
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        jump = 1'b0;
        jump_target = '0;

        #3;
        check_ifid("reset", 32'h0, 32'h0, 1'b0);
        check("reset addr", bus.imem_addr, 32'h0);
        check("reset done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        step();
        check("idle addr", bus.imem_addr, 32'h0);
        check("idle valid", {31'd0, bus.ifid_valid}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("run entry addr", bus.imem_addr, 32'h0);
        check("run entry valid", {31'd0, bus.ifid_valid}, 32'd0);

        for (int k = 1; k <= 12; k++) begin
            step();
            check_ifid($sformatf("seq%0d", k), 32'(4 * k), word_at(32'(4 * (k - 1))), 1'b1);
            check($sformatf("seq%0d addr", k), bus.imem_addr, 32'(4 * k));
        end
        step();
        check_ifid("end", 32'h0, 32'h0, 1'b0);
        check("end done", {31'd0, done}, 32'd1);
        check("end addr", bus.imem_addr, 32'd48);
        step();
        check("done hold addr", bus.imem_addr, 32'd48);
        check("done hold done", {31'd0, done}, 32'd1);

        start = 1'b1;
        step();
        check("restart done", {31'd0, done}, 32'd0);
        check("restart addr", bus.imem_addr, 32'h0);
        check("restart valid", {31'd0, bus.ifid_valid}, 32'd0);
        step();
        start = 1'b0;
        check_ifid("restart first", 32'h4, word_at(32'h0), 1'b1);
        check("start ignored in run", bus.imem_addr, 32'h4);
        step();
        check_ifid("pre stall", 32'h8, word_at(32'h4), 1'b1);
        check("pre stall addr", bus.imem_addr, 32'h8);

        stall = 1'b1;
        step();
        check_ifid("stall1", 32'h8, word_at(32'h4), 1'b1);
        check("stall1 addr", bus.imem_addr, 32'h8);
        step();
        check_ifid("stall2", 32'h8, word_at(32'h4), 1'b1);
        check("stall2 addr", bus.imem_addr, 32'h8);
        stall = 1'b0;
        step();
        check_ifid("post stall", 32'hC, word_at(32'h8), 1'b1);
        step();
        check("pre branch addr", bus.imem_addr, 32'h10);

        branch_taken = 1'b1;
        branch_target = 32'h20;
        step();
        branch_taken = 1'b0;
        check("branch addr", bus.imem_addr, 32'h20);
        check("branch valid", {31'd0, bus.ifid_valid}, 32'd0);
        step();
        check_ifid("branch target", 32'h24, word_at(32'h20), 1'b1);
        check("branch next addr", bus.imem_addr, 32'h24);

        jump = 1'b1;
        jump_target = 32'h08;
        branch_taken = 1'b1;
        branch_target = 32'h28;
        stall = 1'b1;
        step();
        check("jump prio addr", bus.imem_addr, 32'h8);
        check_ifid("jump prio", 32'h0, 32'h0, 1'b0);
        branch_taken = 1'b0;
        stall = 1'b0;
        jump_target = 32'h23;
        step();
        jump = 1'b0;
        check("jump align addr", bus.imem_addr, 32'h20);
        step();
        check_ifid("jump target", 32'h24, word_at(32'h20), 1'b1);

        rst_n = 1'b0;
        #2;
        check_ifid("async reset", 32'h0, 32'h0, 1'b0);
        check("async reset addr", bus.imem_addr, 32'h0);
        check("async reset done", {31'd0, done}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("post reset idle valid", {31'd0, bus.ifid_valid}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("resume addr", bus.imem_addr, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check_ifid($sformatf("resume%0d", k), 32'(4 * k), word_at(32'(4 * (k - 1))), 1'b1);
        end
        step();
        check("resume done", {31'd0, done}, 32'd1);

        jump = 1'b1;
        jump_target = 32'h10;
        branch_taken = 1'b1;
        branch_target = 32'h14;
        stall = 1'b1;
        step();
        jump = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        check("done ignores redirect addr", bus.imem_addr, 32'd48);
        check("done ignores redirect done", {31'd0, done}, 32'd1);
        check("done ignores redirect valid", {31'd0, bus.ifid_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the pipelined MIPS CPU. Owns the program counter, drives the byte address into the byte-addressed, big-endian instruction memory and captures the returned word into the IF/ID pipeline register. Handles hazard-unit stalls, branch/jump redirects with IF/ID flush, and start/done sequencing for the finite program image. Downstream consumer is the decode stage.

Parameters:
PC_RESET, 32'h0000_0000, PC value after reset and on (re)start
PROG_BYTES, 48, program image size in bytes; PC >= PROG_BYTES ends the program
NOP_WORD, 32'h0000_0000, instruction inserted as a bubble (sll $0,$0,0)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  level/pulse; begins fetching from PC_RESET
stall  in  1  hazard unit: hold PC and IF/ID
branch_taken  in  1  branch resolved taken in ID
branch_target  in  32  branch byte address
jump  in  1  jump resolved in ID
jump_target  in  32  jump byte address
imem_addr  out  32  byte address to instruction memory (combinational = pc)
imem_instr  in  32  instruction word returned combinationally for imem_addr
ifid_instr  out  32  registered instruction to decode
ifid_pc4  out  32  registered PC+4 of that instruction
ifid_valid  out  1  1 = ifid_instr is a real fetched instruction
done  out  1  program exhausted

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst_n low, immediate, no clock needed): state=IDLE, pc=PC_RESET, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0, done=0.
- imem_addr = pc at all times; imem_instr is sampled at the same clock edge that updates pc.
- IDLE: pc held, IF/ID loads bubble (NOP_WORD, pc4=0, valid=0). start=1 -> RUN next edge; pc stays PC_RESET.
- RUN, per edge, priority highest first:
  1. jump: pc<=jump_target; IF/ID<=bubble.
  2. branch_taken: pc<=branch_target; IF/ID<=bubble.
  3. stall: pc and all IF/ID outputs hold.
  4. pc >= PROG_BYTES: pc held, IF/ID<=bubble, state<=DONE, done<=1.
  5. else: ifid_instr<=imem_instr, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4.
- Redirect beats stall; jump beats branch. Target low 2 bits forced to 0 before loading pc.
- pc+4 is mod 2^32 (0xFFFF_FFFC wraps to 0); out-of-range check uses unsigned compare.
- Latency: instruction at address A appears on ifid_instr one edge after imem_addr=A is presented.
- start in RUN ignored. DONE: done=1, IF/ID bubble, jump/branch/stall ignored; start=1 -> pc<=PC_RESET, done<=0, state<=RUN.
- Reset mid-operation: all state returns to reset values asynchronously; deassertion is synchronous to clk by the surrounding design.

Decomposition:
- cpu_pkg: NOP_WORD, PC width, fetch state enum (IDLE/RUN/DONE), PROG_BYTES default.
- One sub-module: ifid_reg (instr/pc4/valid register with load, hold, bubble controls, async active-low reset); fetch_unit holds FSM, PC and next-PC mux.

Test Plan:
- Reset, start pulse at cycle 2, 12-word memory model -> ifid_pc4 = 4,8,...,48 on consecutive cycles with valid=1, matching words; then valid=0, done=1, imem_addr held at 48.
- stall high 2 cycles while pc=0x08 -> imem_addr stays 0x08, ifid_pc4 stays 0x08 and instr unchanged; after release ifid_pc4=0x0C.
- branch_taken, target 0x20, while pc=0x10 -> next edge pc=0x20, ifid_valid=0; following edge ifid_pc4=0x24 with word at 0x20.
- jump=1 target 0x08 and branch_taken=1 target 0x28 with stall=1, same cycle -> pc=0x08, IF/ID bubble; target 0x23 -> pc=0x20.
- rst_n low mid-RUN between edges -> outputs at reset values before next edge; start after release -> fetch resumes at 0x00.
- In DONE, start=1 -> done=0, refetch from PC_RESET, ifid_pc4=4 one edge after entering RUN.
